// File: rtl/reorder_buffer_if.sv
// Reorder buffer payload type and the issue/commit/writeback bundle.
// The master modport is the pipeline side; the slave modport is the buffer.
package reorder_buffer_pkg;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        exc;
  } rob_entry_t;

endpackage

interface reorder_buffer_if;
  import reorder_buffer_pkg::*;

  logic       alloc_i;
  logic [5:0] tag_o;
  logic       full_o;
  logic       empty_o;
  logic       rob_write_i;
  logic [5:0] rob_tag_i;
  rob_entry_t rob_entry_i;
  logic       valid_o;
  rob_entry_t entry_o;
  logic       read_i;

  modport master (
    output alloc_i, rob_write_i, rob_tag_i, rob_entry_i, read_i,
    input  tag_o, full_o, empty_o, valid_o, entry_o
  );

  modport slave (
    input  alloc_i, rob_write_i, rob_tag_i, rob_entry_i, read_i,
    output tag_o, full_o, empty_o, valid_o, entry_o
  );

endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocation, out-of-order completion by
// tag, in-order drain from the head.
// Optional feature macro: ROB_BYPASS_EN -- forwards a write that targets the
// not-yet-done head entry straight to the read port in the same cycle.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            flush_i,
  input  logic            stall_i,
  reorder_buffer_if.slave rob
);

  localparam logic [6:0] FULL_CNT = 7'(DEPTH);

  logic [5:0]       head_q, head_d;
  logic [5:0]       tail_q, tail_d;
  logic [6:0]       count_q, count_d;
  logic [DEPTH-1:0] done_q, done_d;
  rob_entry_t       mem_q [DEPTH];

  logic       full;
  logic       empty;
  logic       head_done;
  logic       bypass;
  logic       valid;
  logic       pop_fire;
  logic       alloc_fire;
  logic       wr_ok;
  logic [5:0] offs;

  // Status decode, window check and head-port view of the current state
  always_comb begin
    full      = (count_q == FULL_CNT);
    empty     = (count_q == 7'd0);
    head_done = done_q[head_q];
    // Distance of the write tag from the head; inside the window when it is
    // below the occupancy (a full buffer makes every tag valid).
    offs      = rob.rob_tag_i - head_q;
    wr_ok     = rob.rob_write_i && ({1'b0, offs} < count_q);
`ifdef ROB_BYPASS_EN
    bypass    = rob.rob_write_i && (rob.rob_tag_i == head_q) && !head_done && !empty;
`else
    bypass    = 1'b0;
`endif
    valid      = (head_done && !empty) || bypass;
    pop_fire   = rob.read_i && valid && !stall_i;
    // At full, an allocation only proceeds when the pop frees its slot
    alloc_fire = rob.alloc_i && (!full || pop_fire);

    rob.tag_o   = tail_q;
    rob.full_o  = full;
    rob.empty_o = empty;
    rob.valid_o = valid;
    rob.entry_o = '0;
    if (valid) begin
      rob.entry_o = bypass ? rob.rob_entry_i : mem_q[head_q];
    end
  end

  // Next-state for pointers, occupancy and done bits; flush wins over all
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    done_d  = done_q;
    if (flush_i) begin
      head_d  = 6'd0;
      tail_d  = 6'd0;
      count_d = 7'd0;
      done_d  = '0;
    end else begin
      // A bypassed pop clears the bit the write just set, leaving it clear
      if (wr_ok) begin
        done_d[rob.rob_tag_i] = 1'b1;
      end
      if (pop_fire) begin
        done_d[head_q] = 1'b0;
        head_d         = head_q + 6'd1;
      end
      if (alloc_fire) begin
        done_d[tail_q] = 1'b0;
        tail_d         = tail_q + 6'd1;
      end
      count_d = count_q + {6'd0, alloc_fire} - {6'd0, pop_fire};
    end
  end

  // Control state registers with asynchronous reset
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      head_q  <= 6'd0;
      tail_q  <= 6'd0;
      count_q <= 7'd0;
      done_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  // Payload storage: no reset, written only for accepted in-window writes
  always_ff @(posedge clk_i) begin
    if (wr_ok && !flush_i) begin
      mem_q[rob.rob_tag_i] <= rob.rob_entry_i;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer with a queue-based reference model.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic clk;
  logic rst_n;
  logic flush;
  logic stall;

  reorder_buffer_if bus();

  reorder_buffer #(.DEPTH(64)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .flush_i (flush),
    .stall_i (stall),
    .rob     (bus)
  );

  always #5 clk = ~clk;

  int checks;
  int failures;

  // Reference model: ordered list of live tags, done flags and payloads
  int         q[$];
  bit         mdone[64];
  rob_entry_t mpay[64];
  int         mtail;

  function automatic void model_clear();
    q.delete();
    foreach (mdone[i]) mdone[i] = 1'b0;
    mtail = 0;
  endfunction

  function automatic bit in_q(int t);
    foreach (q[i]) if (q[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_byp();
`ifdef ROB_BYPASS_EN
    return bus.rob_write_i && (q.size() > 0) && (int'(bus.rob_tag_i) == q[0]) && !mdone[q[0]];
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_valid();
    if (q.size() == 0) return 1'b0;
    return mdone[q[0]] || m_byp();
  endfunction

  function automatic rob_entry_t m_entry();
    if (!m_valid()) return '0;
    if (m_byp()) return bus.rob_entry_i;
    return mpay[q[0]];
  endfunction

  function automatic rob_entry_t rnd_e();
    rob_entry_t e;
    e.rd   = 5'($urandom);
    e.data = $urandom;
    e.exc  = 1'($urandom);
    return e;
  endfunction

  task automatic drive(input bit a, input bit w, input int wt, input rob_entry_t we,
                       input bit r, input bit s, input bit f);
    bus.alloc_i     = a;
    bus.rob_write_i = w;
    bus.rob_tag_i   = 6'(wt);
    bus.rob_entry_i = we;
    bus.read_i      = r;
    stall           = s;
    flush           = f;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, '0, 0, 0, 0);
  endtask

  // Advance the model by one clock using the inputs currently applied
  task automatic tick();
    bit pop, al, wok;
    int t;
    pop = bus.read_i && m_valid() && !stall;
    al  = bus.alloc_i && (q.size() < 64 || pop);
    t   = int'(bus.rob_tag_i);
    wok = bus.rob_write_i && in_q(t);
    if (flush) begin
      model_clear();
    end else begin
      if (wok) begin
        mpay[t]  = bus.rob_entry_i;
        mdone[t] = 1'b1;
      end
      if (pop) begin
        mdone[q[0]] = 1'b0;
        void'(q.pop_front());
      end
      if (al) begin
        mdone[mtail] = 1'b0;
        q.push_back(mtail);
        mtail = (mtail + 1) % 64;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, '0, 0, 0, 0);
      tick();
    end
    idle();
    rst_n = 1'b0;
    model_clear();
    #2;
    checks++;
    if (bus.tag_o !== 6'd0 || bus.full_o !== 1'b0 || bus.empty_o !== 1'b1 ||
        bus.valid_o !== 1'b0 || bus.entry_o !== '0) begin
      failures++;
      $display("FAIL reset: tag=%0d full=%b empty=%b valid=%b entry=%h, need 0/0/1/0/0",
               bus.tag_o, bus.full_o, bus.empty_o, bus.valid_o, bus.entry_o);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 64; i++) begin
      drive(1, 0, 0, '0, 0, 0, 0);
      checks++;
      if (bus.tag_o !== 6'(i) || bus.full_o !== 1'b0) begin
        failures++;
        $display("FAIL fill_tag: tag=%0d full=%b, need %0d/0", bus.tag_o, bus.full_o, i);
      end
      tick();
    end
    idle();
    checks++;
    if (bus.full_o !== 1'b1 || bus.tag_o !== 6'd0 || bus.empty_o !== 1'b0) begin
      failures++;
      $display("FAIL fill_full: full=%b tag=%0d empty=%b, need 1/0/0",
               bus.full_o, bus.tag_o, bus.empty_o);
    end
    drive(1, 0, 0, '0, 0, 0, 0);
    tick();
    idle();
    checks++;
    if (bus.full_o !== 1'b1 || bus.tag_o !== 6'd0 || q.size() != 64) begin
      failures++;
      $display("FAIL fill_over: full=%b tag=%0d, need 1/0", bus.full_o, bus.tag_o);
    end
  endtask

  task automatic test_out_of_order();
    rob_entry_t p[4];
    int seq[3] = '{3, 1, 2};
    int first;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      p[i] = rnd_e();
      drive(1, 0, 0, '0, 0, 0, 0);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, seq[k], p[seq[k]], 1, 0, 0);
      checks++;
      if (bus.valid_o !== 1'b0) begin
        failures++;
        $display("FAIL ooo_wait: valid=%b after write of tag %0d, need 0", bus.valid_o, seq[k]);
      end
      tick();
    end
    drive(0, 1, 0, p[0], 1, 0, 0);
`ifdef ROB_BYPASS_EN
    checks++;
    if (bus.valid_o !== 1'b1 || bus.entry_o !== p[0]) begin
      failures++;
      $display("FAIL ooo_head_bypass: valid=%b entry=%h, need 1/%h", bus.valid_o, bus.entry_o, p[0]);
    end
    first = 1;
`else
    checks++;
    if (bus.valid_o !== 1'b0) begin
      failures++;
      $display("FAIL ooo_head_write: valid=%b, need 0", bus.valid_o);
    end
    first = 0;
`endif
    tick();
    for (int k = first; k < 4; k++) begin
      drive(0, 0, 0, '0, 1, 0, 0);
      checks++;
      if (bus.valid_o !== 1'b1 || bus.entry_o !== p[k]) begin
        failures++;
        $display("FAIL ooo_pop%0d: valid=%b entry=%h, need 1/%h", k, bus.valid_o, bus.entry_o, p[k]);
      end
      tick();
    end
    idle();
    checks++;
    if (bus.empty_o !== 1'b1 || bus.valid_o !== 1'b0) begin
      failures++;
      $display("FAIL ooo_empty: empty=%b valid=%b, need 1/0", bus.empty_o, bus.valid_o);
    end
  endtask

  task automatic test_stall();
    rob_entry_t e;
    e = rnd_e();
    do_reset();
    drive(1, 0, 0, '0, 0, 0, 0);
    tick();
    drive(0, 1, 0, e, 0, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, '0, 1, 1, 0);
      checks++;
      if (bus.valid_o !== 1'b1 || bus.entry_o !== e || bus.empty_o !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold%0d: valid=%b entry=%h empty=%b, need 1/%h/0",
                 i, bus.valid_o, bus.entry_o, bus.empty_o, e);
      end
      tick();
    end
    drive(0, 0, 0, '0, 1, 0, 0);
    tick();
    idle();
    checks++;
    if (bus.empty_o !== 1'b1 || bus.valid_o !== 1'b0) begin
      failures++;
      $display("FAIL stall_release: empty=%b valid=%b, need 1/0", bus.empty_o, bus.valid_o);
    end
  endtask

  task automatic test_wrap();
    rob_entry_t e63, e0, e5;
    e63 = rnd_e();
    e0  = rnd_e();
    e5  = rnd_e();
    do_reset();
    for (int i = 0; i < 63; i++) begin
      drive(1, 0, 0, '0, 0, 0, 0);
      tick();
      drive(0, 1, i, rnd_e(), 0, 0, 0);
      tick();
      drive(0, 0, 0, '0, 1, 0, 0);
      tick();
    end
    idle();
    checks++;
    if (bus.tag_o !== 6'd63 || bus.empty_o !== 1'b1) begin
      failures++;
      $display("FAIL wrap_pos: tag=%0d empty=%b, need 63/1", bus.tag_o, bus.empty_o);
    end
    drive(1, 0, 0, '0, 0, 0, 0);
    tick();
    drive(1, 0, 0, '0, 0, 0, 0);
    tick();
    drive(0, 1, 5, e5, 1, 0, 0);
    checks++;
    if (bus.tag_o !== 6'd1 || bus.valid_o !== 1'b0) begin
      failures++;
      $display("FAIL wrap_drop5: tag=%0d valid=%b, need 1/0", bus.tag_o, bus.valid_o);
    end
    tick();
    drive(0, 1, 0, e0, 1, 0, 0);
    checks++;
    if (bus.valid_o !== 1'b0) begin
      failures++;
      $display("FAIL wrap_w0: valid=%b, need 0", bus.valid_o);
    end
    tick();
    drive(0, 1, 63, e63, 0, 0, 0);
    tick();
    drive(0, 0, 0, '0, 1, 0, 0);
    checks++;
    if (bus.valid_o !== 1'b1 || bus.entry_o !== e63) begin
      failures++;
      $display("FAIL wrap_pop63: valid=%b entry=%h, need 1/%h", bus.valid_o, bus.entry_o, e63);
    end
    tick();
    drive(0, 0, 0, '0, 1, 0, 0);
    checks++;
    if (bus.valid_o !== 1'b1 || bus.entry_o !== e0) begin
      failures++;
      $display("FAIL wrap_pop0: valid=%b entry=%h, need 1/%h", bus.valid_o, bus.entry_o, e0);
    end
    tick();
    idle();
    checks++;
    if (bus.empty_o !== 1'b1 || bus.valid_o !== 1'b0 || bus.tag_o !== 6'd1) begin
      failures++;
      $display("FAIL wrap_end: empty=%b valid=%b tag=%0d, need 1/0/1 (tag 5 must not surface)",
               bus.empty_o, bus.valid_o, bus.tag_o);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 0, '0, 0, 0, 0);
      tick();
    end
    drive(0, 1, 0, rnd_e(), 0, 0, 0);
    tick();
    drive(1, 1, 3, rnd_e(), 1, 0, 1);
    tick();
    idle();
    checks++;
    if (bus.tag_o !== 6'd0 || bus.empty_o !== 1'b1 || bus.valid_o !== 1'b0 || bus.full_o !== 1'b0) begin
      failures++;
      $display("FAIL flush: tag=%0d empty=%b valid=%b full=%b, need 0/1/0/0",
               bus.tag_o, bus.empty_o, bus.valid_o, bus.full_o);
    end
  endtask

  task automatic test_bypass();
    rob_entry_t e;
    e = rnd_e();
    do_reset();
    drive(1, 0, 0, '0, 0, 0, 0);
    tick();
    drive(0, 1, 0, e, 1, 0, 0);
`ifdef ROB_BYPASS_EN
    checks++;
    if (bus.valid_o !== 1'b1 || bus.entry_o !== e) begin
      failures++;
      $display("FAIL bypass_same: valid=%b entry=%h, need 1/%h", bus.valid_o, bus.entry_o, e);
    end
    tick();
`else
    checks++;
    if (bus.valid_o !== 1'b0) begin
      failures++;
      $display("FAIL bypass_none: valid=%b, need 0", bus.valid_o);
    end
    tick();
    drive(0, 0, 0, '0, 1, 0, 0);
    checks++;
    if (bus.valid_o !== 1'b1 || bus.entry_o !== e) begin
      failures++;
      $display("FAIL bypass_next: valid=%b entry=%h, need 1/%h", bus.valid_o, bus.entry_o, e);
    end
    tick();
`endif
    idle();
    checks++;
    if (bus.empty_o !== 1'b1 || bus.valid_o !== 1'b0) begin
      failures++;
      $display("FAIL bypass_popped: empty=%b valid=%b, need 1/0", bus.empty_o, bus.valid_o);
    end
  endtask

  task automatic test_random();
    logic [5+1+1+1+$bits(rob_entry_t)-1:0] act, exp;
    int bad;
    bit a, w, r, s, f;
    int wt;
    bad = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      a = ($urandom % 8) < ((c / 500) % 2 ? 7 : 3);
      w = ($urandom % 2) == 1;
      if (q.size() > 0 && ($urandom % 4) != 0) wt = q[$urandom % q.size()];
      else wt = int'($urandom % 64);
      r = ($urandom % 4) != 0;
      s = ($urandom % 5) == 0;
      f = ($urandom % 150) == 0;
      drive(a, w, wt, rnd_e(), r, s, f);
      exp = {6'(mtail), q.size() == 64, q.size() == 0, m_valid(), m_entry()};
      act = {bus.tag_o, bus.full_o, bus.empty_o, bus.valid_o, bus.entry_o};
      checks++;
      if (act !== exp) begin
        failures++;
        if (bad < 10)
          $display("FAIL random cycle %0d: got %h, need %h", c, act, exp);
        bad++;
      end
      tick();
    end
  endtask

  initial begin
    clk      = 1'b0;
    rst_n    = 1'b0;
    checks   = 0;
    failures = 0;
    idle();
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_fill();
    test_out_of_order();
    test_stall();
    test_wrap();
    test_flush();
    test_bypass();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
